// File: rtl/reg_write_arbiter.sv
// Round-robin write arbiter that drives the d input of a load-enable-less register.
// Each granted write takes three cycles: IDLE -> WRITE (drive data) -> ACK.
module reg_write_arbiter #(
  parameter int NBITS = 16,
  parameter int NREQ  = 4,
  parameter int IDW   = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*NBITS-1:0] wr_data,
  input  logic [NBITS-1:0]      reg_q,
  output logic [NBITS-1:0]      reg_d,
  output logic [NREQ-1:0]       grant,
  output logic [NREQ-1:0]       ack,
  output logic [IDW-1:0]        owner,
  output logic                  busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    ACK   = 2'd2
  } state_t;

  state_t           state_r, state_s;
  logic [IDW-1:0]   ptr_r, ptr_s;
  logic [IDW-1:0]   owner_r, owner_s;
  logic [NBITS-1:0] hold_r, hold_s;
  logic [NREQ-1:0]  grant_r, grant_s;
  logic [NREQ-1:0]  ack_r, ack_s;
  logic             busy_r, busy_s;
  logic [NBITS-1:0] data_arr [NREQ];
  logic [IDW-1:0]   pick_s;
  logic             pick_valid_s;

  // Unpack the flat requester data bus into one word per requester.
  always_comb begin
    for (int k = 0; k < NREQ; k++) begin
      data_arr[k] = wr_data[k*NBITS +: NBITS];
    end
  end

  // Round-robin search starting at ptr; index arithmetic wraps because NREQ = 2**IDW.
  always_comb begin
    logic [IDW-1:0] idx;
    logic           hit;
    pick_s       = ptr_r;
    pick_valid_s = 1'b0;
    idx          = ptr_r;
    hit          = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      idx          = ptr_r + IDW'(i);
      hit          = req[idx] & ~pick_valid_s;
      pick_s       = hit ? idx : pick_s;
      pick_valid_s = pick_valid_s | req[idx];
    end
  end

  // Next-state logic; grant/ack/busy are computed one cycle early so they leave registered.
  always_comb begin
    state_s = state_r;
    ptr_s   = ptr_r;
    owner_s = owner_r;
    hold_s  = hold_r;
    grant_s = {NREQ{1'b0}};
    ack_s   = {NREQ{1'b0}};
    busy_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (pick_valid_s) begin
          state_s         = WRITE;
          owner_s         = pick_s;
          hold_s          = data_arr[pick_s];
          grant_s[pick_s] = 1'b1;
          busy_s          = 1'b1;
        end else begin
          state_s = IDLE;
        end
      end
      WRITE: begin
        state_s        = ACK;
        ptr_s          = owner_r + IDW'(1);
        ack_s[owner_r] = 1'b1;
        busy_s         = 1'b1;
      end
      ACK: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State and registered outputs; async reset drops grant immediately, losing an uncaptured write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      ptr_r   <= {IDW{1'b0}};
      owner_r <= {IDW{1'b0}};
      hold_r  <= {NBITS{1'b0}};
      grant_r <= {NREQ{1'b0}};
      ack_r   <= {NREQ{1'b0}};
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      ptr_r   <= ptr_s;
      owner_r <= owner_s;
      hold_r  <= hold_s;
      grant_r <= grant_s;
      ack_r   <= ack_s;
      busy_r  <= busy_s;
    end
  end

  // The register has no enable, so outside WRITE its own value is fed back.
  always_comb begin
    if (state_r == WRITE) begin
      reg_d = hold_r;
    end else begin
      reg_d = reg_q;
    end
  end

  assign grant = grant_r;
  assign ack   = ack_r;
  assign owner = owner_r;
  assign busy  = busy_r;

  reg_write_arbiter_checker #(
    .NREQ (NREQ)
  ) u_checker (
    .clk   (clk),
    .rst   (rst),
    .grant (grant_r),
    .ack   (ack_r),
    .busy  (busy_r)
  );

endmodule

// Protocol invariants of the arbiter outputs.
module reg_write_arbiter_checker #(
  parameter int NREQ = 4
) (
  input logic            clk,
  input logic            rst,
  input logic [NREQ-1:0] grant,
  input logic [NREQ-1:0] ack,
  input logic            busy
);

  a_grant_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(grant));
  a_ack_onehot:   assert property (@(posedge clk) disable iff (rst) $onehot0(ack));
  a_exclusive:    assert property (@(posedge clk) disable iff (rst) !((|grant) && (|ack)));
  a_busy:         assert property (@(posedge clk) disable iff (rst) ((|grant) || (|ack)) |-> busy);

endmodule
